// File: rtl/spi_ram_bridge_pkg.sv
// Shared types and constants for the SPI-to-RAM bridge.
package spi_ram_bridge_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam int CMD_WRITE_BIT = 7;
   localparam int BYTE_LEN      = 8;
   localparam int DEF_ADDR_BITS = 2;
endpackage

// File: rtl/spi_ram_bridge_sync.sv
// Multi-flop synchronizer for one SPI pin followed by a rise/fall detector.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = din;
      prev_d    = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~prev_q;
   assign fall = ~dout & prev_q;
endmodule

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave that turns command/data frames into byte reads and writes on a small RAM.
//   state   | meaning
//   ST_IDLE | waiting for cs_n to fall
//   ST_CMD  | shifting in the command byte (rw bit + start address)
//   ST_DATA | burst of data bytes, address auto-increments until cs_n rises
module spi_ram_bridge
   import spi_ram_bridge_pkg::*;
#(
   parameter int ADDR_BITS   = DEF_ADDR_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_sclk,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata,
   output logic                 busy
);
   logic sclk_sync_unused, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(spi_sclk),
      .dout(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
      .dout(cs_sync), .rise(cs_rise), .fall(cs_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(spi_mosi),
      .dout(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   state_e               state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 is_write_q, is_write_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]           mem_wdata_q, mem_wdata_d;
   logic                 mem_we_q, mem_we_d;
   logic [7:0]           tx_q, tx_d;
   logic                 load_q, load_d;
   logic [7:0]           byte_w;
   logic                 byte_done;

   assign byte_w    = {shift_q[6:0], mosi_sync};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'(BYTE_LEN - 1));

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      is_write_d  = is_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      tx_d        = tx_q;
      load_d      = 1'b0;

      if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_BITS'(1);
      if (load_q)   tx_d       = mem_rdata;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
               shift_d   = 8'h00;
               tx_d      = 8'h00;
            end
         end
         ST_CMD, ST_DATA: begin
            if (sclk_rise) begin
               shift_d   = byte_w;
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // the fall right after a byte boundary keeps the freshly loaded bit 7 on the pin
            if (state_q == ST_DATA && sclk_fall && bit_cnt_q != 3'd0)
               tx_d = {tx_q[6:0], 1'b0};
            if (byte_done) begin
               if (state_q == ST_CMD) begin
                  is_write_d = byte_w[CMD_WRITE_BIT];
                  mem_addr_d = byte_w[ADDR_BITS-1:0];
                  load_d     = ~byte_w[CMD_WRITE_BIT];
                  state_d    = ST_DATA;
               end else if (is_write_q) begin
                  mem_wdata_d = byte_w;
                  mem_we_d    = 1'b1;
               end else begin
                  mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                  load_d     = 1'b1;
               end
            end else if (cs_sync || cs_rise) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         is_write_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         tx_q        <= 8'h00;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         is_write_q  <= is_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         tx_q        <= tx_d;
         load_q      <= load_d;
      end
   end

   assign spi_miso_oe = ~cs_sync;
   assign spi_miso    = (state_q == ST_DATA) && !is_write_q && !cs_sync && tx_q[7];
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = (state_q != ST_IDLE);
endmodule
